lnrv_icb_wrr_arbiter: RTL

LNRV_ICB_WRR_ARBITER -- requirements
Module: lnrv_icb_wrr_arbiter

---
 rtl/lnrv_icb_wrr_arbiter.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/lnrv_icb_wrr_arbiter.sv
// Weighted round-robin command arbiter for a shared ICB slave port. An in-order
// owner FIFO routes each response back to the master that issued the command.
module lnrv_icb_wrr_arbiter #(
    parameter int P_ICB_COUNT    = 4,
    parameter int P_WEIGHT_WIDTH = 4,
    parameter int P_OTS_COUNT    = 2
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic [P_ICB_COUNT-1:0]                mn_req,
    input  logic [P_WEIGHT_WIDTH*P_ICB_COUNT-1:0] mn_weight,
    input  logic                                  cmd_hsked,
    input  logic                                  rsp_hsked,
    output logic [P_ICB_COUNT-1:0]                grant,
    output logic                                  grant_vld,
    output logic [P_ICB_COUNT-1:0]                rsp_sel,
    output logic                                  rsp_sel_vld,
    output logic                                  ots_full
);

    localparam int IW = (P_ICB_COUNT > 1) ? $clog2(P_ICB_COUNT) : 1;
    localparam int PW = (P_OTS_COUNT > 1) ? $clog2(P_OTS_COUNT) : 1;
    localparam int CW = $clog2(P_OTS_COUNT + 1);
    localparam int WW = P_WEIGHT_WIDTH;

    localparam logic [0:0]    S_IDLE        = 1'b0;
    localparam logic [0:0]    S_OWN         = 1'b1;
    localparam logic [IW-1:0] LP_LAST_IDX   = IW'(P_ICB_COUNT - 1);
    localparam logic [PW-1:0] LP_PTR_MAX    = PW'(P_OTS_COUNT - 1);
    localparam logic [CW-1:0] LP_CNT_FULL   = CW'(P_OTS_COUNT);
    localparam logic [CW-1:0] LP_CNT_ONE    = CW'(1);
    localparam logic [WW-1:0] LP_CREDIT_ONE = WW'(1);

    // One-hot to binary index; input is guaranteed one-hot or zero.
    function automatic logic [IW-1:0] f_onehot_idx(input logic [P_ICB_COUNT-1:0] oh);
        logic [IW-1:0] idx;
        idx = {IW{1'b0}};
        for (int i = 0; i < P_ICB_COUNT; i++) begin
            idx = idx | (oh[i] ? IW'(i) : {IW{1'b0}});
        end
        return idx;
    endfunction

    // First requester after 'last', wrapping; returns one-hot or zero.
    function automatic logic [P_ICB_COUNT-1:0] f_rr_pick(input logic [P_ICB_COUNT-1:0] req,
                                                         input logic [IW-1:0]          last);
        logic [P_ICB_COUNT-1:0] pick;
        logic                   found;
        int                     idx;
        pick  = {P_ICB_COUNT{1'b0}};
        found = 1'b0;
        for (int k = 1; k <= P_ICB_COUNT; k++) begin
            idx = (int'(last) + k) % P_ICB_COUNT;
            if (req[idx] && !found) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    function automatic logic [PW-1:0] f_ptr_inc(input logic [PW-1:0] ptr);
        return (ptr == LP_PTR_MAX) ? {PW{1'b0}} : ptr + PW'(1);
    endfunction

    logic [0:0]             r_state;
    logic [P_ICB_COUNT-1:0] r_grant;
    logic                   r_grant_vld;
    logic [WW-1:0]          r_credit;
    logic [IW-1:0]          r_last_owner;
    logic [P_ICB_COUNT-1:0] r_fifo [P_OTS_COUNT];
    logic [PW-1:0]          r_wptr;
    logic [PW-1:0]          r_rptr;
    logic [CW-1:0]          r_count;
    logic [P_ICB_COUNT-1:0] r_rsp_sel;
    logic                   r_rsp_sel_vld;
    logic                   r_ots_full;

    logic                   w_cmd_vld;
    logic                   w_pop;
    logic                   w_owner_req;
    logic [P_ICB_COUNT-1:0] w_pick;
    logic [IW-1:0]          w_pick_idx;
    logic [WW-1:0]          w_pick_weight;
    logic [0:0]             w_state_nxt;
    logic [P_ICB_COUNT-1:0] w_grant_nxt;
    logic [WW-1:0]          w_credit_nxt;
    logic [IW-1:0]          w_last_nxt;
    logic [CW-1:0]          w_count_nxt;
    logic [PW-1:0]          w_wptr_nxt;
    logic [PW-1:0]          w_rptr_nxt;
    logic [P_ICB_COUNT-1:0] w_head_nxt;

    assign w_cmd_vld     = r_grant_vld & cmd_hsked;
    assign w_pop         = rsp_hsked & r_rsp_sel_vld;
    assign w_owner_req   = |(mn_req & r_grant);
    assign w_pick        = f_rr_pick(mn_req, r_last_owner);
    assign w_pick_idx    = f_onehot_idx(w_pick);
    assign w_pick_weight = mn_weight[w_pick_idx*WW +: WW];

    // Ownership FSM: arbitrate in IDLE, burn credit per handshake in OWN.
    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_credit_nxt = r_credit;
        w_last_nxt   = r_last_owner;
        case (r_state)
            S_IDLE: begin
                if (|mn_req) begin
                    w_state_nxt  = S_OWN;
                    w_grant_nxt  = w_pick;
                    w_credit_nxt = (w_pick_weight == {WW{1'b0}}) ? LP_CREDIT_ONE : w_pick_weight;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_OWN: begin
                if (w_cmd_vld && (r_credit == LP_CREDIT_ONE)) begin
                    w_state_nxt  = S_IDLE;
                    w_grant_nxt  = {P_ICB_COUNT{1'b0}};
                    w_credit_nxt = {WW{1'b0}};
                    w_last_nxt   = f_onehot_idx(r_grant);
                end else if (w_cmd_vld) begin
                    w_credit_nxt = r_credit - LP_CREDIT_ONE;
                end else if (!w_owner_req) begin
                    w_state_nxt  = S_IDLE;
                    w_grant_nxt  = {P_ICB_COUNT{1'b0}};
                    w_credit_nxt = {WW{1'b0}};
                    w_last_nxt   = f_onehot_idx(r_grant);
                end else begin
                    w_state_nxt = S_OWN;
                end
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_grant_nxt  = {P_ICB_COUNT{1'b0}};
                w_credit_nxt = {WW{1'b0}};
            end
        endcase
    end

    // Order FIFO bookkeeping and the next head, including write-through when
    // the entry being pushed becomes the head in the same cycle.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_cmd_vld, w_pop})
            2'b10:   w_count_nxt = r_count + LP_CNT_ONE;
            2'b01:   w_count_nxt = r_count - LP_CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
        w_wptr_nxt = w_cmd_vld ? f_ptr_inc(r_wptr) : r_wptr;
        w_rptr_nxt = w_pop ? f_ptr_inc(r_rptr) : r_rptr;
        if (w_count_nxt == {CW{1'b0}}) begin
            w_head_nxt = {P_ICB_COUNT{1'b0}};
        end else if (w_cmd_vld && (w_rptr_nxt == r_wptr)) begin
            w_head_nxt = r_grant;
        end else begin
            w_head_nxt = r_fifo[w_rptr_nxt];
        end
    end

    // State, FIFO and registered output updates.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_grant       <= {P_ICB_COUNT{1'b0}};
            r_grant_vld   <= 1'b0;
            r_credit      <= {WW{1'b0}};
            r_last_owner  <= LP_LAST_IDX;
            r_wptr        <= {PW{1'b0}};
            r_rptr        <= {PW{1'b0}};
            r_count       <= {CW{1'b0}};
            r_rsp_sel     <= {P_ICB_COUNT{1'b0}};
            r_rsp_sel_vld <= 1'b0;
            r_ots_full    <= 1'b0;
            for (int i = 0; i < P_OTS_COUNT; i++) begin
                r_fifo[i] <= {P_ICB_COUNT{1'b0}};
            end
        end else begin
            r_state       <= w_state_nxt;
            r_grant       <= w_grant_nxt;
            r_grant_vld   <= (w_state_nxt == S_OWN) && (w_count_nxt != LP_CNT_FULL);
            r_credit      <= w_credit_nxt;
            r_last_owner  <= w_last_nxt;
            r_wptr        <= w_wptr_nxt;
            r_rptr        <= w_rptr_nxt;
            r_count       <= w_count_nxt;
            r_rsp_sel     <= w_head_nxt;
            r_rsp_sel_vld <= (w_count_nxt != {CW{1'b0}});
            r_ots_full    <= (w_count_nxt == LP_CNT_FULL);
            if (w_cmd_vld) begin
                r_fifo[r_wptr] <= r_grant;
            end else begin
                r_fifo[r_wptr] <= r_fifo[r_wptr];
            end
        end
    end

    assign grant       = r_grant;
    assign grant_vld   = r_grant_vld;
    assign rsp_sel     = r_rsp_sel;
    assign rsp_sel_vld = r_rsp_sel_vld;
    assign ots_full    = r_ots_full;

endmodule
